led_fader: RTL
==============

// Module: led_fader
// PURPOSE
//  Multi-channel LED fade engine: per-channel level ramps (fade-to-target or breathe) driving PWM outputs.
//  All channels share one PWM counter and one step tick; a single-write port configures each channel.
//  Replaces per-LED hand-written fade logic in top-level designs (status/RGB LEDs on iCE40 boards).
// PARAMETERS
//  CLK_FREQ   12_000_000  input clock frequency, Hz
//  PWM_FREQ   1_000       PWM frame rate, Hz; prescale PRE = max(1, CLK_FREQ/(PWM_FREQ*2^WIDTH))
//  STEP_FREQ  50          ramp step rate, Hz; tick every STEP_DIV = max(1, CLK_FREQ/STEP_FREQ) cycles
//  CHANNELS   3           number of channels, >=1
//  WIDTH      8           level / duty resolution, bits, 2..16
//  (local) CW = (CHANNELS>1) ? $clog2(CHANNELS) : 1
// PORTS
//  clk       in   1           system clock; all logic on posedge
//  nRst      in   1           asynchronous, active-low reset
//  enable    in   1           1 = run; 0 = freeze counters/levels, outputs off
//  wrEn      in   1           write strobe, one channel per cycle
//  wrChan    in   CW          channel index for write
//  wrMode    in   2           00 OFF, 01 STATIC, 10 FADE, 11 BREATHE
//  wrLevel   in   WIDTH       STATIC level / FADE target / BREATHE peak
//  level     out  CHANNELS*WIDTH  current level, channel i at [i*WIDTH +: WIDTH]
//  pwmOut    out  CHANNELS    active-high PWM
//  nPwmOut   out  CHANNELS    active-low PWM (~pwmOut while enable=1, all 1 when enable=0)
//  rampDone  out  CHANNELS    1 when level == target (FADE) / always 1 in OFF, STATIC; 0 in BREATHE
// BEHAVIOUR
//  Reset (nRst=0, async): modes OFF, level/target/duty 0, dir up, prescalers+counters 0,
//   pwmOut 0, nPwmOut all 1, rampDone all 1. Release takes effect on next posedge.
//  PWM: cnt (WIDTH bits) advances every PRE cycles, wraps 2^WIDTH-1 -> 0. duty[i] loads from level[i]
//   when cnt wraps to 0 (glitch-free). pwmOut[i] = (cnt < duty[i]), registered; duty 0 = never high,
//   full scale = high except cnt == 2^WIDTH-1.
//  Step tick: internal 1-cycle pulse every STEP_DIV enabled cycles; first tick STEP_DIV cycles after reset.
//  Write (wrEn=1, wrChan<CHANNELS): mode/target stored, visible next cycle. wrChan>=CHANNELS: ignored.
//   OFF: level <= 0 immediately. STATIC: level <= wrLevel immediately.
//   FADE: level unchanged at write; each tick level moves +-1 toward target; holds when equal.
//   BREATHE: level unchanged, dir <= up; each tick +-1; at level>=peak dir down, at level==0 dir up
//    (turn happens on the same tick: peak->peak-1, 0->1). Peak 0 -> level stays 0.
//    Level above new peak on write: descends by 1 per tick until 0, then bounces.
//  Write and tick same cycle on same channel: write wins, no step that cycle; other channels step.
//  Re-write mid-ramp: ramp continues from current level toward new target; no jump.
//  Arithmetic: level never wraps; saturates within 0..2^WIDTH-1.
//  enable=0: prescalers, cnt, tick counter, levels hold; writes still accepted (mode/target stored,
//   OFF/STATIC level update applied); pwmOut 0, nPwmOut 1. enable 0->1 resumes from held counts.
//  Latency: write -> level 1 cycle; level -> duty at next PWM frame start; duty -> pwmOut 1 cycle.
// CONFIGURATION
//  LED_FADER_GAMMA_EN defined: duty[i] = (level*level) >> WIDTH, i.e. square-law perceptual curve
//   (full scale 2^WIDTH-1 maps to 2^WIDTH-2); computed combinationally before duty load.
//  Not defined: duty[i] = level[i] (linear). level output is linear in both builds.
// TESTING  (sim params: CLK_FREQ=2560, PWM_FREQ=10 -> PRE=1, STEP_FREQ=256 -> STEP_DIV=10, WIDTH=8, CHANNELS=3)
//  1 Reset: nRst=0 mid-run -> same cycle pwmOut=000, nPwmOut=111, level=0, rampDone=111.
//  2 STATIC ch1=64 -> level[1]=64 next cycle; after next frame start pwmOut[1] high exactly 64 of 256 cycles.
//  3 FADE ch0 0->5 -> level 1,2,3,4,5 on 5 ticks (10-cycle spacing), rampDone[0] 0 until level 5, then 1, holds.
//  4 BREATHE ch2 peak=3 -> tick sequence 1,2,3,2,1,0,1,...; rampDone[2]=0; write OFF mid-ramp -> level 0 next cycle.
//  5 Write ch0 on tick cycle during FADE -> ch0 no step that tick, ch1 FADE still steps; wrChan=3 -> no change anywhere.
//  6 enable=0 for 50 cycles -> pwmOut=000, nPwmOut=111, levels frozen; re-enable resumes same sequence;
//    with LED_FADER_GAMMA_EN, STATIC 128 -> 64 high cycles per frame.

Source files
------------

// File: rtl/led_fader_if.sv
// Channel configuration write port for led_fader.
// wrEn is a one-cycle valid with no ready: every write is accepted and it configures one channel per cycle.
interface led_fader_if #(
  parameter int CW    = 2,
  parameter int WIDTH = 8
);
  logic             wrEn;
  logic [CW-1:0]    wrChan;
  logic [1:0]       wrMode;
  logic [WIDTH-1:0] wrLevel;

  modport master (output wrEn, wrChan, wrMode, wrLevel);
  modport slave  (input  wrEn, wrChan, wrMode, wrLevel);
endinterface

// File: rtl/led_fader.sv
// led_fader: multi-channel LED fade engine (OFF / STATIC / FADE / BREATHE) with one shared PWM counter.
// Optional build macro LED_FADER_GAMMA_EN selects a square-law duty curve; the level output stays linear.
module led_fader #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int PWM_FREQ  = 1_000,
  parameter int STEP_FREQ = 50,
  parameter int CHANNELS  = 3,
  parameter int WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      enable,
  led_fader_if.slave                wr,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       pwmOut,
  output logic [CHANNELS-1:0]       nPwmOut,
  output logic [CHANNELS-1:0]       rampDone
);

  localparam int PRE_RAW  = CLK_FREQ / (PWM_FREQ * (2 ** WIDTH));
  localparam int PRE      = (PRE_RAW < 1) ? 1 : PRE_RAW;
  localparam int DIV_RAW  = CLK_FREQ / STEP_FREQ;
  localparam int STEP_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW       = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int TW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_FADE    = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  logic [PW-1:0]    preCnt;
  logic [WIDTH-1:0] cnt;
  logic [TW-1:0]    tickCnt;
  logic             advance, frameWrap, tick;

  mode_t            mode     [CHANNELS];
  mode_t            modeNext [CHANNELS];
  logic [WIDTH-1:0] lvl      [CHANNELS];
  logic [WIDTH-1:0] lvlNext  [CHANNELS];
  logic [WIDTH-1:0] tgt      [CHANNELS];
  logic [WIDTH-1:0] tgtNext  [CHANNELS];
  logic [WIDTH-1:0] duty     [CHANNELS];
  logic [WIDTH-1:0] dutySrc  [CHANNELS];
  logic             dirDown     [CHANNELS];
  logic             dirDownNext [CHANNELS];
  logic [CHANNELS-1:0] pwmRaw;

  assign advance   = enable && (preCnt == PRE_LAST);
  assign frameWrap = advance && (cnt == '1);
  assign tick      = enable && (tickCnt == STEP_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      preCnt  <= '0;
      cnt     <= '0;
      tickCnt <= '0;
    end else if (enable) begin
      preCnt  <= advance ? '0 : preCnt + 1'b1;
      tickCnt <= tick ? '0 : tickCnt + 1'b1;
      if (advance) cnt <= cnt + 1'b1;
    end
  end

  // A write to a channel takes priority over that channel's step on the same cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      modeNext[i]    = mode[i];
      lvlNext[i]     = lvl[i];
      tgtNext[i]     = tgt[i];
      dirDownNext[i] = dirDown[i];
      if (wr.wrEn && (int'(wr.wrChan) == i)) begin
        modeNext[i] = mode_t'(wr.wrMode);
        tgtNext[i]  = wr.wrLevel;
        case (mode_t'(wr.wrMode))
          MODE_OFF:     lvlNext[i] = '0;
          MODE_STATIC:  lvlNext[i] = wr.wrLevel;
          MODE_BREATHE: dirDownNext[i] = 1'b0;
          default:      ;
        endcase
      end else if (tick) begin
        case (mode[i])
          MODE_FADE: begin
            if (lvl[i] < tgt[i])      lvlNext[i] = lvl[i] + 1'b1;
            else if (lvl[i] > tgt[i]) lvlNext[i] = lvl[i] - 1'b1;
          end
          MODE_BREATHE: begin
            if (tgt[i] == '0) begin
              if (lvl[i] != '0) lvlNext[i] = lvl[i] - 1'b1;
            end else if (dirDown[i]) begin
              if (lvl[i] == '0) begin
                lvlNext[i]     = WIDTH'(1);
                dirDownNext[i] = 1'b0;
              end else begin
                lvlNext[i] = lvl[i] - 1'b1;
              end
            end else if (lvl[i] >= tgt[i]) begin
              lvlNext[i]     = lvl[i] - 1'b1;
              dirDownNext[i] = 1'b1;
            end else begin
              lvlNext[i] = lvl[i] + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] l);
    return WIDTH'(({{WIDTH{1'b0}}, l} * {{WIDTH{1'b0}}, l}) >> WIDTH);
  endfunction
`else
  function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] l);
    return l;
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) dutySrc[i] = shape(lvl[i]);
  end

  // Duty only reloads at frame start so a level change never cuts a PWM period short.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pwmRaw <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]    <= MODE_OFF;
        lvl[i]     <= '0;
        tgt[i]     <= '0;
        dirDown[i] <= 1'b0;
        duty[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]    <= modeNext[i];
        lvl[i]     <= lvlNext[i];
        tgt[i]     <= tgtNext[i];
        dirDown[i] <= dirDownNext[i];
        if (frameWrap) duty[i] <= dutySrc[i];
        pwmRaw[i]  <= (cnt < duty[i]);
      end
    end
  end

  always_comb begin
    level    = '0;
    rampDone = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      level[i*WIDTH +: WIDTH] = lvl[i];
      case (mode[i])
        MODE_FADE:    rampDone[i] = (lvl[i] == tgt[i]);
        MODE_BREATHE: rampDone[i] = 1'b0;
        default:      rampDone[i] = 1'b1;
      endcase
    end
  end

  assign pwmOut  = pwmRaw & {CHANNELS{enable}};
  assign nPwmOut = ~pwmOut;

endmodule
